// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-master command arbiter in front of the SRAM controller.
// m0 (data side) and m1 (instruction side) share the mem_* command port.
// Reads are tagged with mem_id, and returned beats are steered back by
// mem_readdataid.
// A master that has an outstanding read burst cannot issue anything else
// until every beat of that burst has returned.
// Build option: define MEM_ARB_FIXED_PRIO_EN to make m0 win every
// simultaneous request. By default, simultaneous requests alternate
// round-robin.
module mem_arbiter2 #(
   parameter int unsigned burst_bits = 2,
   parameter logic [1:0]  m0_id      = 2'd1,
   parameter logic [1:0]  m1_id      = 2'd2
) (
   input  logic        clock,
   input  logic        rst,

   output logic        m0_waitrequest,
   input  logic [29:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_writedatamask,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,

   output logic        m1_waitrequest,
   input  logic [29:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_writedatamask,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,

   input  logic        mem_waitrequest,
   output logic [1:0]  mem_id,
   output logic [29:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_writedatamask,
   input  logic [31:0] mem_readdata,
   input  logic [1:0]  mem_readdataid
);

   localparam int unsigned CW = burst_bits + 1;
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t CNT_FULL = cnt_t'(1) << burst_bits;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_M0   = 2'd1,
      GNT_M1   = 2'd2
   } gnt_t;

   // run holds the arbiter idle until the first edge after reset release,
   // so no grant can appear while reset is asserted.
   logic  run;
   logic  lock, lock_n;
   gnt_t  lock_gnt, lock_gnt_n;
   gnt_t  last, last_n;
   cnt_t  cnt0, cnt0_n;
   cnt_t  cnt1, cnt1_n;

   gnt_t  grant;
   logic  elig0, elig1;
   logic  accept;
   logic  beat0, beat1;

   // Arbitration: a locked grant is frozen; otherwise choose among eligible masters
   always_comb begin
      elig0 = run && (m0_read || m0_write) && (cnt0 == '0);
      elig1 = run && (m1_read || m1_write) && (cnt1 == '0);
      grant = GNT_NONE;
      if (lock) begin
         grant = lock_gnt;
      end else if (elig0 && elig1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         grant = GNT_M0;
`else
         grant = (last == GNT_M0) ? GNT_M1 : GNT_M0;
`endif
      end else if (elig0) begin
         grant = GNT_M0;
      end else if (elig1) begin
         grant = GNT_M1;
      end
   end

   // Command mux and per-master stall: only the granted master sees mem_waitrequest
   always_comb begin
      mem_id            = '0;
      mem_address       = '0;
      mem_read          = 1'b0;
      mem_write         = 1'b0;
      mem_writedata     = '0;
      mem_writedatamask = '0;
      m0_waitrequest    = 1'b1;
      m1_waitrequest    = 1'b1;
      case (grant)
         GNT_M0: begin
            mem_id            = m0_id;
            mem_address       = m0_address;
            mem_read          = m0_read;
            mem_write         = m0_write;
            mem_writedata     = m0_writedata;
            mem_writedatamask = m0_writedatamask;
            m0_waitrequest    = mem_waitrequest;
         end
         GNT_M1: begin
            mem_id            = m1_id;
            mem_address       = m1_address;
            mem_read          = m1_read;
            mem_write         = m1_write;
            mem_writedata     = m1_writedata;
            mem_writedatamask = m1_writedatamask;
            m1_waitrequest    = mem_waitrequest;
         end
         default: ;
      endcase
   end

   // Next state: lock/last bookkeeping, burst load on read accept, beat countdown
   always_comb begin
      accept     = (grant != GNT_NONE) && !mem_waitrequest;
      beat0      = (mem_readdataid == m0_id) && (cnt0 != '0);
      beat1      = (mem_readdataid == m1_id) && (cnt1 != '0);
      lock_n     = lock;
      lock_gnt_n = lock_gnt;
      last_n     = last;
      cnt0_n     = cnt0;
      cnt1_n     = cnt1;
      if (grant != GNT_NONE) begin
         if (mem_waitrequest) begin
            lock_n     = 1'b1;
            lock_gnt_n = grant;
         end else begin
            lock_n     = 1'b0;
            last_n     = grant;
         end
      end
      // An eligible master has cnt==0, so a load never competes with a valid beat
      if (accept && (grant == GNT_M0) && mem_read)
         cnt0_n = CNT_FULL;
      else if (beat0)
         cnt0_n = cnt0 - 1'b1;
      if (accept && (grant == GNT_M1) && mem_read)
         cnt1_n = CNT_FULL;
      else if (beat1)
         cnt1_n = cnt1 - 1'b1;
   end

   // State registers and the one-cycle registered return path
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         run              <= 1'b0;
         lock             <= 1'b0;
         lock_gnt         <= GNT_NONE;
         last             <= GNT_M1;
         cnt0             <= '0;
         cnt1             <= '0;
         m0_readdata      <= '0;
         m0_readdatavalid <= 1'b0;
         m1_readdata      <= '0;
         m1_readdatavalid <= 1'b0;
      end else begin
         run              <= 1'b1;
         lock             <= lock_n;
         lock_gnt         <= lock_gnt_n;
         last             <= last_n;
         cnt0             <= cnt0_n;
         cnt1             <= cnt1_n;
         m0_readdata      <= mem_readdata;
         m0_readdatavalid <= beat0;
         m1_readdata      <= mem_readdata;
         m1_readdatavalid <= beat1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Scoreboard bench for mem_arbiter2 in its default round-robin build.
// The bench plays both masters and the downstream controller.
// Expected commands and returned beats are queued as stimulus is issued.
// A negedge monitor pops and compares them whenever the DUT presents an
// accepted command or a readdatavalid pulse.
`timescale 1ns/1ps
module tb_mem_arbiter2;

   logic        clock = 1'b0;
   logic        rst   = 1'b1;

   logic        m0_waitrequest, m1_waitrequest;
   logic [29:0] m0_address, m1_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic [3:0]  m0_writedatamask, m1_writedatamask;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;

   logic        mem_waitrequest;
   logic [1:0]  mem_id;
   logic [29:0] mem_address;
   logic        mem_read, mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_writedatamask;
   logic [31:0] mem_readdata;
   logic [1:0]  mem_readdataid;

   mem_arbiter2 #(.burst_bits(2), .m0_id(2'd1), .m1_id(2'd2)) dut (
      .clock(clock), .rst(rst),
      .m0_waitrequest(m0_waitrequest), .m0_address(m0_address),
      .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_writedatamask(m0_writedatamask), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_waitrequest(m1_waitrequest), .m1_address(m1_address),
      .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_writedatamask(m1_writedatamask), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .mem_waitrequest(mem_waitrequest), .mem_id(mem_id),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_writedatamask(mem_writedatamask),
      .mem_readdata(mem_readdata), .mem_readdataid(mem_readdataid)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  id;
      logic [29:0] addr;
      logic        rd;
      logic        wr;
      logic [31:0] data;
      logic [3:0]  mask;
   } cmd_t;

   cmd_t        exp_cmd[$];
   logic [31:0] exp_rd0[$];
   logic [31:0] exp_rd1[$];
   cmd_t        mon_e;
   logic [31:0] mon_d;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          last_beat_cyc = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic set_master(input int m, input logic rd, input logic wr, input logic [29:0] addr,
                             input logic [31:0] data, input logic [3:0] mask);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = addr;
         m0_writedata = data; m0_writedatamask = mask;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = addr;
         m1_writedata = data; m1_writedatamask = mask;
      end
   endtask

   // Present a command, hold it until accepted, report the accept cycle
   task automatic master_req(input int m, input logic rd, input logic wr, input logic [29:0] addr,
                             input logic [31:0] data, input logic [3:0] mask,
                             input int max_cyc, output int acc);
      bit done;
      done = 1'b0;
      acc  = -1;
      set_master(m, rd, wr, addr, data, mask);
      for (int c = 0; c < max_cyc && !done; c++) begin
         @(negedge clock);
         if (((m == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
            acc  = cyc;
            done = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      set_master(m, 1'b0, 1'b0, '0, '0, '0);
      check($sformatf("m%0d_accept_within_budget", m), 64'(done), 64'd1);
   endtask

   // Drive one returned beat for a cycle; to_master < 0 means no delivery expected
   task automatic send_beat(input logic [1:0] id, input logic [31:0] d, input int to_master);
      mem_readdataid = id;
      mem_readdata   = d;
      if (to_master == 0) exp_rd0.push_back(d);
      else if (to_master == 1) exp_rd1.push_back(d);
      last_beat_cyc = cyc;
      tick;
      mem_readdataid = '0;
   endtask

   // Monitor: every accepted command and every returned beat must match the queue head
   always @(negedge clock) begin
      if ((mem_read || mem_write) && !mem_waitrequest) begin
         if (exp_cmd.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_unexpected: got id=%0d addr=0x%0h rd=%0b wr=%0b, expected none",
                     mem_id, mem_address, mem_read, mem_write);
         end else begin
            mon_e = exp_cmd.pop_front();
            check("cmd_id",   64'(mem_id),            64'(mon_e.id));
            check("cmd_addr", 64'(mem_address),       64'(mon_e.addr));
            check("cmd_rd",   64'(mem_read),          64'(mon_e.rd));
            check("cmd_wr",   64'(mem_write),         64'(mon_e.wr));
            check("cmd_data", 64'(mem_writedata),     64'(mon_e.data));
            check("cmd_mask", 64'(mem_writedatamask), 64'(mon_e.mask));
         end
      end
      if (m0_readdatavalid) begin
         if (exp_rd0.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL m0_beat_unexpected: got data=0x%0h, expected no beat", m0_readdata);
         end else begin
            mon_d = exp_rd0.pop_front();
            check("m0_beat_data", 64'(m0_readdata), 64'(mon_d));
         end
      end
      if (m1_readdatavalid) begin
         if (exp_rd1.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL m1_beat_unexpected: got data=0x%0h, expected no beat", m1_readdata);
         end else begin
            mon_d = exp_rd1.pop_front();
            check("m1_beat_data", 64'(m1_readdata), 64'(mon_d));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, t0;
      set_master(0, 1'b0, 1'b0, '0, '0, '0);
      set_master(1, 1'b0, 1'b0, '0, '0, '0);
      mem_waitrequest = 1'b0;
      mem_readdataid  = '0;
      mem_readdata    = 32'hA5A5_5A5A;
      #1 rst = 1'b0;

      // Reset hold with m0 requesting: no command, no return data
      m0_read    = 1'b1;
      m0_address = 30'h100;
      repeat (3) @(posedge clock);
      #1;
      check("rst_mem_read",  64'(mem_read),         64'd0);
      check("rst_m0_valid",  64'(m0_readdatavalid), 64'd0);
      check("rst_m0_rdata",  64'(m0_readdata),      64'd0);
      check("rst_m0_wait",   64'(m0_waitrequest),   64'd1);
      exp_cmd.push_back('{2'd1, 30'h100, 1'b1, 1'b0, 32'h0, 4'h0});
      rst = 1'b1;
      #1;
      check("rel_mem_read_before_edge", 64'(mem_read), 64'd0);
      tick;
      check("rel_mem_read", 64'(mem_read), 64'd1);
      check("rel_mem_id",   64'(mem_id),   64'd1);
      tick;
      set_master(0, 1'b0, 1'b0, '0, '0, '0);
      for (int k = 0; k < 4; k++) send_beat(2'd1, 32'h1000_0000 + k, 0);
      tick;

      // Asynchronous mid-run reset clears return registers without an edge
      rst = 1'b0;
      #1;
      check("arst_m0_rdata", 64'(m0_readdata),      64'd0);
      check("arst_m1_rdata", 64'(m1_readdata),      64'd0);
      check("arst_m0_valid", 64'(m0_readdatavalid), 64'd0);
      tick;
      rst = 1'b1;

      // Simultaneous reads: last=m1 after reset, so m0 first, m1 next cycle
      exp_cmd.push_back('{2'd1, 30'h100, 1'b1, 1'b0, 32'h0, 4'h0});
      exp_cmd.push_back('{2'd2, 30'h200, 1'b1, 1'b0, 32'h0, 4'h0});
      fork
         master_req(0, 1'b1, 1'b0, 30'h100, 32'h0, 4'h0, 10, a0);
         master_req(1, 1'b1, 1'b0, 30'h200, 32'h0, 4'h0, 10, a1);
      join
      check("t2_m1_follows_m0", 64'(a1), 64'(a0 + 1));
      for (int k = 0; k < 4; k++) send_beat(2'd1, 32'h2000_0000 + k, 0);
      for (int k = 0; k < 4; k++) send_beat(2'd2, 32'h2100_0000 + k, 1);
      tick;

      // m0 write so that last=m0; the lock test below then relies on lock alone
      exp_cmd.push_back('{2'd1, 30'h44, 1'b0, 1'b1, 32'h1234_5678, 4'hF});
      master_req(0, 1'b0, 1'b1, 30'h44, 32'h1234_5678, 4'hF, 10, a0);

      // Stalled m0 write stays granted while m1 starts requesting
      exp_cmd.push_back('{2'd1, 30'h40,  1'b0, 1'b1, 32'hDEAD_BEEF, 4'h3});
      exp_cmd.push_back('{2'd2, 30'h300, 1'b1, 1'b0, 32'h0,         4'h0});
      mem_waitrequest = 1'b1;
      t0 = cyc;
      fork
         master_req(0, 1'b0, 1'b1, 30'h40, 32'hDEAD_BEEF, 4'h3, 20, a0);
         begin
            tick;
            master_req(1, 1'b1, 1'b0, 30'h300, 32'h0, 4'h0, 20, a1);
         end
         begin
            for (int k = 0; k < 2; k++) begin
               tick;
               #2;
               check("t3_lock_addr", 64'(mem_address),    64'h40);
               check("t3_lock_wr",   64'(mem_write),      64'd1);
               check("t3_lock_id",   64'(mem_id),         64'd1);
               check("t3_m1_wait",   64'(m1_waitrequest), 64'd1);
               check("t3_m0_wait",   64'(m0_waitrequest), 64'd1);
            end
            tick;
            mem_waitrequest = 1'b0;
         end
      join
      check("t3_m0_accept_cycle", 64'(a0), 64'(t0 + 3));
      check("t3_m1_accept_cycle", 64'(a1), 64'(t0 + 4));

      // m1 re-requests with its burst outstanding: issued one cycle after the 4th beat
      exp_cmd.push_back('{2'd2, 30'h304, 1'b1, 1'b0, 32'h0, 4'h0});
      fork
         master_req(1, 1'b1, 1'b0, 30'h304, 32'h0, 4'h0, 30, a1);
         begin
            tick;
            for (int k = 0; k < 4; k++) send_beat(2'd2, 32'h3000_0000 + k, 1);
         end
      join
      check("t4_reissue_cycle", 64'(a1), 64'(last_beat_cyc + 1));

      // Foreign id and beats for an idle m0 are dropped; m0 counter stays at 0
      tick;
      send_beat(2'd3, 32'h5555_0000, -1);
      send_beat(2'd1, 32'h5555_0001, -1);
      send_beat(2'd1, 32'h5555_0002, -1);
      tick;
      exp_cmd.push_back('{2'd1, 30'h500, 1'b1, 1'b0, 32'h0, 4'h0});
      t0 = cyc;
      master_req(0, 1'b1, 1'b0, 30'h500, 32'h0, 4'h0, 10, a0);
      check("t5_m0_immediate", 64'(a0), 64'(t0));

      // Drain both bursts, each followed by one spurious extra beat
      for (int k = 0; k < 4; k++) send_beat(2'd2, 32'h6200_0000 + k, 1);
      send_beat(2'd2, 32'h62FF_FFFF, -1);
      for (int k = 0; k < 4; k++) send_beat(2'd1, 32'h6100_0000 + k, 0);
      send_beat(2'd1, 32'h61FF_FFFF, -1);
      tick;
      tick;
      exp_cmd.push_back('{2'd2, 30'h600, 1'b0, 1'b1, 32'hCAFE_F00D, 4'hC});
      t0 = cyc;
      master_req(1, 1'b0, 1'b1, 30'h600, 32'hCAFE_F00D, 4'hC, 10, a1);
      check("t5_m1_no_wrap", 64'(a1), 64'(t0));

      repeat (3) tick;
      check("end_cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
      check("end_rd0_queue_empty", 64'(exp_rd0.size()), 64'd0);
      check("end_rd1_queue_empty", 64'(exp_rd1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
